// File: rtl/imem_fetch.sv
// Instruction fetch front-end: owns the fetch PC, issues one ROM read per cycle
// and buffers the 1-cycle ROM latency in a 2-entry skid FIFO ahead of decode.
module imem_fetch #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc
);

  logic [31:0]           fetch_pc;
  logic [31:0]           inflight_pc;
  logic                  inflight;
  logic [31:0]           tail_pc;
  logic [DATA_WIDTH-1:0] tail_instr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic [31:0]           redirect_word;
  logic [2:0]            occ;
  logic                  pop;
  logic                  push;
  logic                  replay;
  logic                  issue;
  logic                  head_load_new;
  logic                  head_load_tail;
  logic                  tail_load;

  assign rom_addr      = fetch_pc[ADDR_WIDTH+1:2];
  assign redirect_word = redirect_pc & ~32'd3;

  assign pop    = out_valid && out_ready;
  assign push   = inflight && rom_rdata_valid;
  assign replay = inflight && !rom_rdata_valid;
  // Words already owned (buffered or on the ROM bus) after this edge's pop;
  // a new read is only issued if there is guaranteed room for its data.
  assign occ    = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue  = !redirect && !replay && (occ < 3'd2);

  // FIFO head lives directly in out_pc/out_instr so the outputs are registered.
  always_comb begin
    head_load_new  = 1'b0;
    head_load_tail = 1'b0;
    tail_load      = 1'b0;
    case (count)
      2'd0: head_load_new = push;
      2'd1: begin
        head_load_new = push && pop;
        tail_load     = push && !pop;
      end
      default: begin
        head_load_tail = pop;
        tail_load      = push;
      end
    endcase
    count_next = count + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      inflight  <= 1'b0;
      count     <= 2'd0;
      out_valid <= 1'b0;
    end else if (redirect) begin
      fetch_pc  <= redirect_word;
      inflight  <= 1'b0;
      count     <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (replay) begin
        fetch_pc <= inflight_pc;
        inflight <= 1'b0;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      count     <= count_next;
      out_valid <= (count_next != 2'd0);
    end
  end

  // Tail entry and inflight PC are qualified by count/inflight, so no reset needed.
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc <= fetch_pc;
    end
    if (tail_load) begin
      tail_pc    <= inflight_pc;
      tail_instr <= rom_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc    <= 32'd0;
      out_instr <= '0;
    end else if (!redirect) begin
      if (head_load_new) begin
        out_pc    <= inflight_pc;
        out_instr <= rom_rdata;
      end else if (head_load_tail) begin
        out_pc    <= tail_pc;
        out_instr <= tail_instr;
      end
    end
  end

endmodule
